// File: rtl/spram_bank_ctrl.sv
// spram_bank_ctrl: turns one external single-port SRAM bank into a valid/ready
// FIFO. Each cycle the single RAM port goes to either a push (write) or a
// prefetch (read) into a 2-entry output buffer; contested cycles alternate.
//
// Handshake: a beat transfers on a rising clk edge where valid & ready are both
// high. The producer holds data stable while valid & ~ready. in_ready never
// depends on in_valid, and out_valid never depends on out_ready.
module spram_bank_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 16,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int CNT_WIDTH  = $clog2(RAM_DEPTH + 3)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(RAM_DEPTH);

    logic [ADDR_WIDTH-1:0]          wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]           ram_cnt_q, ram_cnt_d;
    logic                           rd_inflight_q, rd_inflight_d;
    logic [1:0][DATA_WIDTH-1:0]     ob_q, ob_d;
    logic [1:0]                     ob_cnt_q, ob_cnt_d;
    logic                           last_rd_q, last_rd_d;

    logic                           rd_req;
    logic                           wr_ok;
    logic                           wr_gnt;
    logic                           rd_gnt;
    logic                           conflict;
    logic                           ob_push;
    logic                           ob_pop;
    logic [1:0]                     ob_wr_idx;

    // Port arbitration: reads prefetch only while the output buffer has room
    // counting the read already in flight; on contention last_rd alternates.
    always_comb begin
        rd_req    = ~rst & (ram_cnt_q != '0)
                    & ((ob_cnt_q + {1'b0, rd_inflight_q}) < 2'd2);
        wr_ok     = ~rst & (ram_cnt_q < DEPTH_CNT);
        in_ready  = wr_ok & (~rd_req | last_rd_q);
        wr_gnt    = in_valid & in_ready;
        rd_gnt    = rd_req & ~wr_gnt;
        conflict  = rd_req & in_valid & wr_ok;
        ram_en    = wr_gnt | rd_gnt;
        ram_we    = wr_gnt;
        ram_addr  = wr_gnt ? wr_ptr_q : rd_ptr_q;
        ram_wdata = in_data;
        out_valid = (ob_cnt_q != 2'd0);
        out_data  = ob_q[0];
        count     = ram_cnt_q + CNT_WIDTH'(rd_inflight_q) + CNT_WIDTH'(ob_cnt_q);
    end

    // Next state: pointers with non-power-of-two wrap, occupancy, and the
    // output buffer which may pop its head and accept returning read data at once.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ram_cnt_d     = ram_cnt_q + CNT_WIDTH'(wr_gnt) - CNT_WIDTH'(rd_gnt);
        rd_inflight_d = rd_gnt;
        last_rd_d     = conflict ? rd_gnt : last_rd_q;
        ob_push       = rd_inflight_q;
        ob_pop        = out_valid & out_ready;
        ob_wr_idx     = ob_cnt_q - {1'b0, ob_pop};
        ob_d          = ob_q;
        ob_cnt_d      = ob_cnt_q + {1'b0, ob_push} - {1'b0, ob_pop};

        if (wr_gnt) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_gnt) begin
            rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (ob_pop) begin
            ob_d[0] = ob_q[1];
        end
        if (ob_push) begin
            if (ob_wr_idx == 2'd0) begin
                ob_d[0] = ram_rdata;
            end else begin
                ob_d[1] = ram_rdata;
            end
        end
    end

    // State registers; reset discards contents including any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            ob_q          <= '0;
            ob_cnt_q      <= 2'd0;
            last_rd_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            ob_q          <= ob_d;
            ob_cnt_q      <= ob_cnt_d;
            last_rd_q     <= last_rd_d;
        end
    end

endmodule

// File: tb/tb_spram_bank_ctrl.sv
// Bench for spram_bank_ctrl: a 16-deep instance with a full scoreboard and a
// 5-deep instance streamed through to exercise non-power-of-two pointer wrap.
module tb_spram_bank_ctrl;

    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- 16-deep DUT ----------------
    logic [DW-1:0] in_data, out_data, ram_wdata, ram_rdata;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic          ram_en, ram_we;
    logic [3:0]    ram_addr;
    logic [4:0]    count;
    logic [DW-1:0] mem [16];

    spram_bank_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .count(count)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    // ---------------- 5-deep DUT ----------------
    logic [DW-1:0] d5_in_data, d5_out_data, d5_wdata, d5_rdata;
    logic          d5_in_valid, d5_in_ready, d5_out_valid, d5_out_ready;
    logic          d5_en, d5_we;
    logic [2:0]    d5_addr;
    logic [2:0]    d5_count;
    logic [DW-1:0] mem5 [8];

    spram_bank_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(5)) u_dut5 (
        .clk(clk), .rst(rst),
        .in_data(d5_in_data), .in_valid(d5_in_valid), .in_ready(d5_in_ready),
        .out_data(d5_out_data), .out_valid(d5_out_valid), .out_ready(d5_out_ready),
        .ram_en(d5_en), .ram_we(d5_we), .ram_addr(d5_addr),
        .ram_wdata(d5_wdata), .ram_rdata(d5_rdata), .count(d5_count)
    );

    always @(posedge clk) begin
        if (d5_en) begin
            if (d5_we) mem5[d5_addr] <= d5_wdata;
            else       d5_rdata <= mem5[d5_addr];
        end
    end

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp5_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    bit            stall_q = 1'b0;
    logic [DW-1:0] held_data = '0;
    int            wr5_idx = 0;
    int            rd5_idx = 0;
    bit            push_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- monitors ----------------
    // 16-deep: pop-order scoreboard plus hold-stable check while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_q) check("hold_stable", {out_valid, out_data}, {1'b1, held_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got 0x%0h, required no output", out_data);
                end else begin
                    check("pop_data", out_data, exp_q.pop_front());
                end
            end
        end
        stall_q   = !rst && out_valid && !out_ready;
        held_data = out_data;
    end

    // 5-deep: addresses follow a modulo-5 sequence, outputs in order.
    always @(negedge clk) begin
        if (rst) begin
            wr5_idx = 0;
            rd5_idx = 0;
        end else begin
            if (d5_en) begin
                if (d5_we) begin
                    check("wrap_waddr", d5_addr, wr5_idx % 5);
                    wr5_idx++;
                end else begin
                    check("wrap_raddr", d5_addr, rd5_idx % 5);
                    rd5_idx++;
                end
            end
            if (d5_out_valid && d5_out_ready) begin
                if (exp5_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pop5_unexpected: got 0x%0h, required no output", d5_out_data);
                end else begin
                    check("pop5_data", d5_out_data, exp5_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks (entered just after a posedge) ----------------
    task automatic push_word(input logic [DW-1:0] d);
        int waits = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (in_ready) exp_q.push_back(d);
        else check("push_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (count == 0 && exp_q.size() == 0) break;
        end
        check({name, "_count"}, count, 0);
        check({name, "_queue"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int lat;
        logic prev_we;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        d5_in_valid = 1'b0;
        d5_in_data = '0;
        d5_out_ready = 1'b1;

        // Reset: pushes refused and RAM idle while rst high, clean state after.
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data = 8'hEE;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_ram_en", ram_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_count", count, 0);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Back-to-back 11/22/33; first output three cycles after its accept.
        out_ready = 1'b1;
        fork
            begin
                push_word(8'h11);
                push_word(8'h22);
                push_word(8'h33);
            end
            begin
                lat = -1;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (in_valid && in_ready && in_data == 8'h11) break;
                end
                for (int j = 1; j <= 10; j++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        lat = j;
                        break;
                    end
                end
                check("latency_cycles", lat, 3);
            end
        join
        drain("drain_basic");

        // Fill with out_ready low: 16 in RAM + 2 in the output buffer.
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        in_data = 8'h40;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(in_data);
                acc++;
            end
            @(posedge clk); #1;
            in_data = 8'(8'h40 + acc);
        end
        in_valid = 1'b0;
        check("fill_accepts", acc, 18);
        @(negedge clk);
        check("fill_count", count, 18);
        check("fill_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("refill_read_en", {ram_en, ram_we}, 2'b10);
        check("refill_ready_wait", in_ready, 0);
        @(negedge clk);
        check("refill_in_ready", in_ready, 1);
        check("refill_count", count, 17);
        @(posedge clk); #1;
        drain("drain_fill");

        // Steady pushes: port busy every cycle, write/read alternate.
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 20; i++) push_word(8'(8'h80 + i));
            end
            begin
                repeat (4) @(negedge clk);
                prev_we = ram_we;
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    check("alt_ram_en", ram_en, 1);
                    check("alt_ram_we", ram_we, !prev_we);
                    prev_we = ram_we;
                end
            end
        join
        drain("drain_alt");

        // Random out_ready back-pressure over 200 pushes.
        push_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) push_word(8'(i * 37 + 5));
                push_done = 1'b1;
            end
            begin
                for (int c = 0; c < 4000 && !push_done; c++) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain("drain_random");

        // Reset with 7 held and a read in flight: nothing old may emerge.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'(8'hC0 + i));
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_count", count, 8);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("inflight_count", count, 7);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_ram_en", ram_en, 0);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_count", count, 0);
        check("midrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        push_word(8'hA5);
        drain("drain_after_rst");

        // 5-deep stream of 0..11: both pointers wrap 4 -> 0.
        for (int i = 0; i < 12; i++) begin
            int w;
            w = 0;
            d5_in_data = 8'(i);
            d5_in_valid = 1'b1;
            @(negedge clk);
            while (!d5_in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (d5_in_ready) exp5_q.push_back(8'(i));
            else check("push5_timeout", 0, 1);
            @(posedge clk); #1;
        end
        d5_in_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (d5_count == 0 && exp5_q.size() == 0) break;
        end
        check("d5_drain_count", d5_count, 0);
        check("d5_drain_queue", exp5_q.size(), 0);
        check("d5_writes", wr5_idx, 12);
        check("d5_reads", rd5_idx, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time bound reached");
        $fatal(1, "watchdog");
    end

endmodule
